// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg
// Shared definitions for the UART APB sequencer:
//   - APB register offsets of the UART slave (DATA, CTRL, BAUDDIV)
//   - FSM state encoding (legacy-compatible localparam constants)
//   - operation type of the transfer currently on the bus
//   - helper to zero-extend a data byte onto the 32-bit write bus
package uart_apb_pkg;

    localparam logic [11:0] ADDR_DATA = 12'h000;
    localparam logic [11:0] ADDR_CTRL = 12'h008;
    localparam logic [11:0] ADDR_BAUD = 12'h010;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef enum logic [1:0] {
        OP_BAUD = 2'd0,
        OP_CTRL = 2'd1,
        OP_DATA = 2'd2
    } op_e;

    // Data bytes go out on the low lane with the upper lanes cleared.
    function automatic logic [31:0] zext_byte(input logic [7:0] b);
        return {24'h00_0000, b};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small circular FIFO for bytes waiting to be written to the UART.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties FIFO)
//   push, wdata       write request and data; ignored while full
//   pop               remove head entry; ignored while empty
//   rdata             current head entry (valid when !empty)
//   full, empty       occupancy flags derived from count
//   count             number of stored entries (0..DEPTH)
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;
    logic             full_s;
    logic             empty_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        full_s    = (count_r == CNT_W'(DEPTH));
        empty_s   = (count_r == {CNT_W{1'b0}});
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty_s;
    end

    // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful where count says so, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

endmodule

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl
// Write-only APB master that programs a UART (BAUDDIV then CTRL after reset
// or on request) and drains a byte FIFO into the DATA register, pacing data
// writes by one UART frame time.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_req/cfg_baud/cfg_ctrl  request a reprogram with the given values
//   tx_valid/tx_data/tx_ready  byte push interface (tx_ready = FIFO not full)
//   err_clr                  clears the sticky timeout flag
//   psel/penable/pwrite/paddr/pwdata/pready  APB master port
//   busy                     FSM active or bytes still queued
//   cfg_done                 last config sequence finished cleanly
//   err_timeout              sticky: an APB access timed out
module uart_apb_ctrl
    import uart_apb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd434,
    parameter logic [31:0] CTRL_RST   = 32'h0000_0001,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [15:0] cfg_baud,
    input  logic [31:0] cfg_ctrl,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        err_clr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [11:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    output logic        busy,
    output logic        cfg_done,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    logic [1:0]       state_r;
    op_e              op_r;
    logic             psel_r;
    logic             penable_r;
    logic             pwrite_r;
    logic [11:0]      paddr_r;
    logic [31:0]      pwdata_r;
    logic             pend_r;
    logic [15:0]      pend_baud_r;
    logic [31:0]      pend_ctrl_r;
    logic [31:0]      run_ctrl_r;
    logic [15:0]      baud_shadow_r;
    logic [15:0]      div_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic             cfg_done_r;
    logic             err_timeout_r;

    logic             start_cfg_s;
    logic             start_data_s;
    logic             xfer_done_s;
    logic             timeout_s;
    logic [15:0]      div_max_s;
    logic             div_wrap_s;
    logic             frame_end_s;
    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (start_data_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // IDLE arbitration: a pending config always beats queued data.
    always_comb begin
        start_cfg_s  = 1'b0;
        start_data_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (pend_r) begin
                start_cfg_s = 1'b1;
            end else if (!fifo_empty_s) begin
                start_data_s = 1'b1;
            end else begin
                start_data_s = 1'b0;
            end
        end else begin
            start_cfg_s = 1'b0;
        end
    end

    // Access-phase outcome and frame-gap counter terminal conditions.
    always_comb begin
        xfer_done_s = 1'b0;
        timeout_s   = 1'b0;
        if (state_r == ST_ACCESS) begin
            xfer_done_s = pready;
            timeout_s   = !pready && (to_cnt_r == TO_W'(TIMEOUT - 1));
        end else begin
            xfer_done_s = 1'b0;
        end
        // A zero divider would never wrap; treat it as one clock per bit.
        if (baud_shadow_r == 16'd0) begin
            div_max_s = 16'd1;
        end else begin
            div_max_s = baud_shadow_r;
        end
        div_wrap_s  = (div_cnt_r == (div_max_s - 16'd1));
        frame_end_s = div_wrap_s && (bit_cnt_r == BIT_W'(FRAME_BITS - 1));
    end

    // Main sequencer: APB phases, op tracking, timeout and gap counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_BAUD;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= 12'h000;
            pwdata_r      <= 32'h0000_0000;
            run_ctrl_r    <= CTRL_RST;
            baud_shadow_r <= BAUD_RST;
            div_cnt_r     <= 16'd0;
            bit_cnt_r     <= {BIT_W{1'b0}};
            to_cnt_r      <= {TO_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_cfg_s) begin
                        state_r    <= ST_SETUP;
                        op_r       <= OP_BAUD;
                        psel_r     <= 1'b1;
                        penable_r  <= 1'b0;
                        pwrite_r   <= 1'b1;
                        paddr_r    <= ADDR_BAUD;
                        pwdata_r   <= {16'h0000, pend_baud_r};
                        // CTRL value is frozen here so a re-queue cannot alter this sequence.
                        run_ctrl_r <= pend_ctrl_r;
                    end else if (start_data_s) begin
                        state_r   <= ST_SETUP;
                        op_r      <= OP_DATA;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b1;
                        paddr_r   <= ADDR_DATA;
                        pwdata_r  <= zext_byte(fifo_head_s);
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                    to_cnt_r  <= {TO_W{1'b0}};
                end
                ST_ACCESS: begin
                    if (pready) begin
                        case (op_r)
                            OP_BAUD: begin
                                // Chain straight into the CTRL setup phase, psel stays high.
                                baud_shadow_r <= pwdata_r[15:0];
                                state_r       <= ST_SETUP;
                                op_r          <= OP_CTRL;
                                penable_r     <= 1'b0;
                                paddr_r       <= ADDR_CTRL;
                                pwdata_r      <= run_ctrl_r;
                            end
                            OP_CTRL: begin
                                state_r   <= ST_IDLE;
                                psel_r    <= 1'b0;
                                penable_r <= 1'b0;
                                pwrite_r  <= 1'b0;
                            end
                            OP_DATA: begin
                                state_r   <= ST_GAP;
                                psel_r    <= 1'b0;
                                penable_r <= 1'b0;
                                pwrite_r  <= 1'b0;
                                div_cnt_r <= 16'd0;
                                bit_cnt_r <= {BIT_W{1'b0}};
                            end
                            default: begin
                                state_r   <= ST_IDLE;
                                psel_r    <= 1'b0;
                                penable_r <= 1'b0;
                                pwrite_r  <= 1'b0;
                            end
                        endcase
                    end else if (timeout_s) begin
                        // Abort: the byte or the rest of the config sequence is dropped.
                        state_r   <= ST_IDLE;
                        psel_r    <= 1'b0;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_GAP: begin
                    // Divider counts clocks per bit, bit counter counts divider wraps.
                    if (frame_end_s) begin
                        state_r <= ST_IDLE;
                    end else if (div_wrap_s) begin
                        div_cnt_r <= 16'd0;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end else begin
                        div_cnt_r <= div_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    psel_r    <= 1'b0;
                    penable_r <= 1'b0;
                    pwrite_r  <= 1'b0;
                end
            endcase
        end
    end

    // Pending config: latched on any request, consumed when a sequence starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r      <= 1'b1;
            pend_baud_r <= BAUD_RST;
            pend_ctrl_r <= CTRL_RST;
        end else if (cfg_req) begin
            pend_r      <= 1'b1;
            pend_baud_r <= cfg_baud;
            pend_ctrl_r <= cfg_ctrl;
        end else if (start_cfg_s) begin
            pend_r <= 1'b0;
        end
    end

    // cfg_done: cleared when a sequence starts, set only by a completed CTRL write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_done_r <= 1'b0;
        end else if (start_cfg_s) begin
            cfg_done_r <= 1'b0;
        end else if (xfer_done_s && (op_r == OP_CTRL)) begin
            cfg_done_r <= 1'b1;
        end
    end

    // Sticky timeout flag; a clear wins over a coincident timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_timeout_r <= 1'b0;
        end else if (err_clr) begin
            err_timeout_r <= 1'b0;
        end else if (timeout_s) begin
            err_timeout_r <= 1'b1;
        end
    end

    assign psel        = psel_r;
    assign penable     = penable_r;
    assign pwrite      = pwrite_r;
    assign paddr       = paddr_r;
    assign pwdata      = pwdata_r;
    assign cfg_done    = cfg_done_r;
    assign err_timeout = err_timeout_r;
    assign tx_ready    = !fifo_full_s;
    assign busy        = (state_r != ST_IDLE) || (fifo_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl
// Directed bench: a monitor logs every completed APB write (address, data,
// setup cycle, completion cycle); the stimulus walks the reset config, a
// baud-4 reconfig, paced data, FIFO overflow, an access timeout, a config
// request during a frame gap and a reset mid-access. The log is compared
// against a table of expected writes, plus spacing checks on selected entries.
module tb_uart_apb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [15:0] cfg_baud;
    logic [31:0] cfg_ctrl;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        err_clr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic        busy;
    logic        cfg_done;
    logic        err_timeout;

    always #5 clk = ~clk;

    uart_apb_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_req     (cfg_req),
        .cfg_baud    (cfg_baud),
        .cfg_ctrl    (cfg_ctrl),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .err_clr     (err_clr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .busy        (busy),
        .cfg_done    (cfg_done),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          setup_cyc;
        int          done_cyc;
    } xfer_t;

    localparam int N_EXP = 19;

    vec_t  exp_tab [N_EXP];
    xfer_t log_q [$];
    int    checks    = 0;
    int    errors    = 0;
    int    cyc       = 0;
    int    cur_setup = 0;
    int    stall_cnt = 0;
    int    pw_bad    = 0;
    int    stall0;

    // Bus monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (psel && !penable) cur_setup <= cyc;
        if (psel && penable && pready) log_q.push_back(xfer_t'{paddr, pwdata, cur_setup, cyc});
        if (psel && penable && !pready) stall_cnt <= stall_cnt + 1;
        if (psel && !pwrite) pw_bad <= pw_bad + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int lim, input string nm);
        int k = 0;
        while (log_q.size() < n && k < lim) begin
            step();
            k++;
        end
        chk(nm, log_q.size(), n);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int k = 0;
        while (busy && k < lim) begin
            step();
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic wait_cfg_done(input int lim, input string nm);
        int k = 0;
        while (!cfg_done && k < lim) begin
            step();
            k++;
        end
        chk(nm, 32'(cfg_done), 32'd1);
    endtask

    task automatic send_cfg(input logic [15:0] b, input logic [31:0] c);
        cfg_req  = 1'b1;
        cfg_baud = b;
        cfg_ctrl = c;
        step();
        cfg_req = 1'b0;
    endtask

    initial begin
        exp_tab[0]  = '{12'h010, 32'd434};
        exp_tab[1]  = '{12'h008, 32'h0000_0001};
        exp_tab[2]  = '{12'h010, 32'd4};
        exp_tab[3]  = '{12'h008, 32'h0000_0001};
        exp_tab[4]  = '{12'h000, 32'h0000_0041};
        exp_tab[5]  = '{12'h000, 32'h0000_0042};
        exp_tab[6]  = '{12'h000, 32'h0000_0060};
        exp_tab[7]  = '{12'h000, 32'h0000_0050};
        exp_tab[8]  = '{12'h000, 32'h0000_0051};
        exp_tab[9]  = '{12'h000, 32'h0000_0052};
        exp_tab[10] = '{12'h000, 32'h0000_0053};
        exp_tab[11] = '{12'h000, 32'h0000_0071};
        exp_tab[12] = '{12'h000, 32'h0000_0080};
        exp_tab[13] = '{12'h010, 32'd8};
        exp_tab[14] = '{12'h008, 32'h0000_0003};
        exp_tab[15] = '{12'h000, 32'h0000_0081};
        exp_tab[16] = '{12'h000, 32'h0000_0082};
        exp_tab[17] = '{12'h010, 32'd434};
        exp_tab[18] = '{12'h008, 32'h0000_0001};

        rst      = 1'b0;
        cfg_req  = 1'b0;
        cfg_baud = 16'd0;
        cfg_ctrl = 32'd0;
        tx_valid = 1'b0;
        tx_data  = 8'd0;
        err_clr  = 1'b0;
        pready   = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);

        // Default config after release
        rst = 1'b1;
        wait_cfg_done(30, "reset_cfg_done");
        chk("reset_cfg_log", log_q.size(), 2);

        // Reconfigure to baud 4; cfg_done must drop when the sequence starts
        send_cfg(16'd4, 32'h0000_0001);
        step();
        chk("cfg_done_cleared", 32'(cfg_done), 32'd0);
        wait_cfg_done(30, "baud4_cfg_done");

        // Two paced data bytes
        push_byte(8'h41);
        push_byte(8'h42);
        wait_idle(300, "two_bytes_idle");

        // Overflow: fill during the gap following byte 0x60
        push_byte(8'h60);
        wait_log(7, 50, "byte60_logged");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("tx_ready_push%0d", i), 32'(tx_ready), (i < 4) ? 32'd1 : 32'd0);
            push_byte(8'h50 + 8'(i));
        end
        chk("tx_ready_full", 32'(tx_ready), 32'd0);
        wait_idle(600, "overflow_idle");

        // Access timeout: byte 0x70 lost, 0x71 follows
        pready = 1'b0;
        stall0 = stall_cnt;
        push_byte(8'h70);
        push_byte(8'h71);
        begin
            int k = 0;
            while (!err_timeout && k < 60) begin
                step();
                k++;
            end
        end
        pready = 1'b1;
        chk("timeout_flag", 32'(err_timeout), 32'd1);
        chk("timeout_cycles", stall_cnt - stall0, 32'd16);
        wait_log(12, 50, "after_timeout_logged");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", 32'(err_timeout), 32'd0);
        wait_idle(200, "timeout_idle");

        // Config request during a gap with two bytes queued
        push_byte(8'h80);
        wait_log(13, 50, "byte80_logged");
        push_byte(8'h81);
        push_byte(8'h82);
        send_cfg(16'd8, 32'h0000_0003);
        wait_idle(600, "cfg_in_gap_idle");
        chk("cfg8_done", 32'(cfg_done), 32'd1);

        // Reset during an access phase
        pready = 1'b0;
        push_byte(8'h90);
        push_byte(8'h91);
        begin
            int k = 0;
            while (!(psel && penable) && k < 20) begin
                step();
                k++;
            end
        end
        chk("reached_access", 32'(psel && penable), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_psel", 32'(psel), 32'd0);
        chk("async_penable", 32'(penable), 32'd0);
        chk("async_tx_ready", 32'(tx_ready), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        step();
        step();
        pready = 1'b1;
        rst = 1'b1;
        wait_cfg_done(30, "rerun_cfg_done");
        step();
        step();
        step();
        chk("fifo_flushed", 32'(busy), 32'd0);

        // Compare the logged writes against the table
        chk("log_count", log_q.size(), N_EXP);
        for (int i = 0; i < N_EXP && i < log_q.size(); i++) begin
            chk($sformatf("xfer%0d_addr", i), 32'(log_q[i].addr), 32'(exp_tab[i].addr));
            chk($sformatf("xfer%0d_data", i), log_q[i].data, exp_tab[i].data);
        end
        if (log_q.size() == N_EXP) begin
            chk("access_len", log_q[0].done_cyc - log_q[0].setup_cyc, 32'd1);
            chk("cfg_back_to_back", log_q[1].setup_cyc - log_q[0].done_cyc, 32'd1);
            // 40 gap cycles + 1 idle cycle, setup in the following cycle
            chk("gap_baud4", log_q[5].setup_cyc - log_q[4].done_cyc, 32'd42);
            chk("gap_baud8", log_q[16].setup_cyc - log_q[15].done_cyc, 32'd82);
        end
        chk("pwrite_with_psel", pw_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_apb_ctrl.md
Name: uart_apb_ctrl

Overview:
APB master that sequences the UART's APB register interface. After reset it programs BAUDDIV (0x10) and then CTRL (0x08). It then drains a small byte FIFO into the DATA register (0x00), pacing writes to one UART frame time, and reconfigures on request. It sits between the system-side byte producer and the UART APB slave port.

Parameters:
FIFO_DEPTH, 4, TX byte FIFO entries (power of 2, ≥2)
BAUD_RST, 16'd434, BAUDDIV value written after reset
CTRL_RST, 32'h0000_0001, CTRL value written after reset (TX enable)
FRAME_BITS, 10, bit times per UART frame (start+8+stop)
TIMEOUT, 16, maximum access-phase cycles waiting for pready

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-low reset
cfg_req  in  1  1-cycle pulse: reprogram using cfg_baud/cfg_ctrl
cfg_baud  in  16  new BAUDDIV, sampled on cfg_req
cfg_ctrl  in  32  new CTRL, sampled on cfg_req
tx_valid  in  1  byte push request
tx_data  in  8  byte to send
tx_ready  out  1  FIFO not full; push accepted when tx_valid&tx_ready
err_clr  in  1  clears err_timeout
psel  out  1  APB select
penable  out  1  APB enable (access phase)
pwrite  out  1  always 1 when psel=1 (write-only master)
paddr  out  12  APB address (0x000/0x008/0x010)
pwdata  out  32  write data; byte writes zero-extended
pready  in  1  slave ready; sampled only in access phase
busy  out  1  FSM not in IDLE, or FIFO not empty
cfg_done  out  1  last config sequence completed without error
err_timeout  out  1  sticky: an access timed out

Behaviour:
- Reset: psel=penable=pwrite=0, paddr=0, pwdata=0, cfg_done=0, err_timeout=0, FIFO empty, tx_ready=1. A config with BAUD_RST/CTRL_RST is pending.
- All outputs are registered except tx_ready (=!full) and busy.
- States: IDLE, SETUP, ACCESS, GAP.
- IDLE: selection priority is (1) pending config, (2) FIFO not empty.
  - Config is a two-write sequence, BAUD then CTRL. The baud value is held in a shadow register (used by GAP).
  - A data write pops the FIFO head on the IDLE->SETUP transition.
- SETUP (1 cycle): psel=1, penable=0, paddr/pwdata valid. Goes to ACCESS.
- ACCESS: psel=1, penable=1.
  - pready=1: the transfer completes. Drop psel/penable next cycle.
    - Config BAUD write: go to SETUP for the CTRL write.
    - Config CTRL write: set cfg_done=1, go to IDLE.
    - Data write: go to GAP.
  - TIMEOUT consecutive access cycles with pready=0: abort. Drop psel/penable, set err_timeout.
    - Aborted data: the byte is discarded.
    - Aborted config: the rest of the sequence is dropped, cfg_done=0.
    - Go to IDLE.
- GAP: nested counters, no multiplier. The divider counts baud_shadow cycles; the bit counter counts FRAME_BITS wraps. The gap is exactly baud_shadow*FRAME_BITS cycles, then IDLE. With baud_shadow=0 the gap is FRAME_BITS cycles (the divider is treated as 1).
- Back-to-back: IDLE to SETUP takes 1 cycle, so the minimum APB transfer spacing is 3 cycles plus the gap.
- cfg_req:
  - Latches cfg_baud/cfg_ctrl and sets pending in any state.
  - It does not interrupt an active transfer or GAP; the new config starts at the next IDLE.
  - cfg_req during a running config sequence re-queues it with the latest values.
  - cfg_done clears when a queued config starts.
- FIFO: circular pointers with a count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Push while full is ignored.
  - Push and pop in the same cycle is legal when not full; the count is unchanged.
  - Pushes are accepted in every state, including during config.
- err_clr has priority over a simultaneous new timeout for that cycle only; the error re-sets on the next timeout.
- Async reset mid-transfer drops psel/penable immediately and empties the FIFO. The default config re-runs after reset release.

Decomposition:
- Shared package uart_apb_pkg:
  - Register offsets ADDR_DATA=12'h000, ADDR_CTRL=12'h008, ADDR_BAUD=12'h010.
  - State encoding (IDLE/SETUP/ACCESS/GAP).
  - Op-type encoding (BAUD/CTRL/DATA).
- One sub-module: uart_tx_fifo (parameterised depth and width, push/pop/full/empty/count). FSM, gap counters and timeout stay in uart_apb_ctrl.

Test Plan:
- Release rst, pready tied 1 -> write paddr 0x010 pwdata 434, then paddr 0x008 pwdata 1. Each transfer is 1 setup + 1 access cycle. cfg_done=1 after the CTRL write.
- BAUD_RST=4 config done, push 0x41, 0x42 -> data writes at paddr 0x000 pwdata 0x41 then 0x42. Second SETUP is exactly 4*10=40 cycles after the first completion plus the IDLE cycle.
- Push 5 bytes with FIFO_DEPTH=4 while GAP holds -> tx_ready=0 after 4. The 5th is dropped; exactly 4 bytes appear on APB.
- pready held 0 on a data write -> abort after 16 access cycles, err_timeout=1, byte lost, next byte proceeds. err_clr -> err_timeout=0.
- cfg_req (baud 8, ctrl 3) during GAP with 2 bytes queued -> after GAP, BAUD=8 and CTRL=3 writes precede the remaining data. The following gap is 80 cycles.
- Assert rst during ACCESS -> psel/penable=0 asynchronously, FIFO empty. After release, the default config sequence repeats.
